// File: rtl/sa_ram_rwsthp_param.sv
// Parametrised 1R1W flop-array RAM with byte-lane write mask, registered read
// address, bypass mux, output register, read-valid tracking and sticky range error.
module sa_ram_rwsthp_param #(
   parameter  int DEPTH     = 20,
   parameter  int WIDTH     = 16,
   parameter  int AW        = 5,
   parameter  int MASK_GRAN = 8,
   localparam int MW        = WIDTH / MASK_GRAN
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [AW-1:0]    ra,
   input  logic             re,
   input  logic             ore,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   input  logic [AW-1:0]    wa,
   input  logic             we,
   input  logic [MW-1:0]    wmask,
   input  logic [WIDTH-1:0] di,
   input  logic             byp_sel,
   input  logic [WIDTH-1:0] dbyp,
   output logic             addr_err,
   input  logic [31:0]      pwrbus_ram_pd
);

   // Index width just wide enough for the array; address bits above it only
   // matter for the range check.
   localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             wa_oor;
   logic             ra_oor;
   logic [WIDTH-1:0] dout_ram;

   logic [IW-1:0]    rd_idx_d,   rd_idx_q;
   logic             rd_oor_d,   rd_oor_q;
   logic             rd_pend_d,  rd_pend_q;
   logic [WIDTH-1:0] dout_d,     dout_q;
   logic             dout_vld_d, dout_vld_q;
   logic             addr_err_d, addr_err_q;

   logic             unused_pwrbus;

   assign unused_pwrbus = ^pwrbus_ram_pd;

   assign wa_oor = ({1'b0, wa} >= DEPTH_W);
   assign ra_oor = ({1'b0, ra} >= DEPTH_W);

   // NOTE: storage has no reset branch on purpose; contents survive rstn and a
   // plain clocked array maps onto RAM/flop primitives without reset fan-out.
   always_ff @(posedge clk) begin
      if (we && !wa_oor) begin
         for (int lane = 0; lane < MW; lane++) begin
            if (wmask[lane]) begin
               mem[wa[IW-1:0]][lane*MASK_GRAN +: MASK_GRAN] <= di[lane*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   // Array is sampled at the ore edge, so writes between re and ore are seen.
   assign dout_ram = rd_oor_q ? '0 : mem[rd_idx_q];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch can be inferred.
      rd_idx_d   = rd_idx_q;
      rd_oor_d   = rd_oor_q;
      rd_pend_d  = rd_pend_q;
      dout_d     = dout_q;
      dout_vld_d = dout_vld_q;
      addr_err_d = addr_err_q | (we & wa_oor) | (re & ra_oor);

      if (ore) begin
         dout_d     = byp_sel ? dbyp : dout_ram;
         dout_vld_d = byp_sel | rd_pend_q;
         rd_pend_d  = 1'b0;
      end

      // A new read on the ore edge wins and keeps the pending flag set.
      if (re) begin
         rd_idx_d  = ra_oor ? '0 : ra[IW-1:0];
         rd_oor_d  = ra_oor;
         rd_pend_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_idx_q   <= '0;
         rd_oor_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_idx_q   <= rd_idx_d;
         rd_oor_q   <= rd_oor_d;
         rd_pend_q  <= rd_pend_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_sa_ram_rwsthp_param.sv
// Bench for sa_ram_rwsthp_param: directed vector table and hand sequences on the
// default size, then random traffic on three sizes against an array model.
module tb_sa_ram_rwsthp_param;

   typedef struct {
      bit          re;
      logic [31:0] ra;
      bit          ore;
      bit          we;
      logic [31:0] wa;
      logic [31:0] wmask;
      logic [63:0] di;
      bit          byp;
      logic [63:0] dbyp;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [15:0] exp_dout;
      bit          exp_vld;
      bit          exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;
   logic [31:0] pwr;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Instance a: 20 x 16, 8-bit lanes
   logic [4:0]  ra_a, wa_a;
   logic        re_a, ore_a, we_a, byp_a, vld_a, err_a;
   logic [1:0]  wm_a;
   logic [15:0] di_a, dbyp_a, dout_a;
   // Instance b: 64 x 32, 8-bit lanes
   logic [5:0]  ra_b, wa_b;
   logic        re_b, ore_b, we_b, byp_b, vld_b, err_b;
   logic [3:0]  wm_b;
   logic [31:0] di_b, dbyp_b, dout_b;
   // Instance c: 3 x 9, single 9-bit lane
   logic [1:0]  ra_c, wa_c;
   logic        re_c, ore_c, we_c, byp_c, vld_c, err_c;
   logic [0:0]  wm_c;
   logic [8:0]  di_c, dbyp_c, dout_c;

   sa_ram_rwsthp_param #(.DEPTH(20), .WIDTH(16), .AW(5), .MASK_GRAN(8)) u_dut_a (
      .clk(clk), .rstn(rstn), .ra(ra_a), .re(re_a), .ore(ore_a), .dout(dout_a),
      .dout_vld(vld_a), .wa(wa_a), .we(we_a), .wmask(wm_a), .di(di_a),
      .byp_sel(byp_a), .dbyp(dbyp_a), .addr_err(err_a), .pwrbus_ram_pd(pwr));

   sa_ram_rwsthp_param #(.DEPTH(64), .WIDTH(32), .AW(6), .MASK_GRAN(8)) u_dut_b (
      .clk(clk), .rstn(rstn), .ra(ra_b), .re(re_b), .ore(ore_b), .dout(dout_b),
      .dout_vld(vld_b), .wa(wa_b), .we(we_b), .wmask(wm_b), .di(di_b),
      .byp_sel(byp_b), .dbyp(dbyp_b), .addr_err(err_b), .pwrbus_ram_pd(pwr));

   sa_ram_rwsthp_param #(.DEPTH(3), .WIDTH(9), .AW(2), .MASK_GRAN(9)) u_dut_c (
      .clk(clk), .rstn(rstn), .ra(ra_c), .re(re_c), .ore(ore_c), .dout(dout_c),
      .dout_vld(vld_c), .wa(wa_c), .we(we_c), .wmask(wm_c), .di(di_c),
      .byp_sel(byp_c), .dbyp(dbyp_c), .addr_err(err_c), .pwrbus_ram_pd(pwr));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.re = 0; s.ra = 0; s.ore = 0; s.we = 0; s.wa = 0;
      s.wmask = 0; s.di = 0; s.byp = 0; s.dbyp = 0;
      return s;
   endfunction

   function automatic stim_t st(bit re, int ra, bit ore, bit we, int wa, int wm,
                                logic [63:0] di, bit byp, logic [63:0] dbyp);
      stim_t s;
      s.re = re; s.ra = ra; s.ore = ore; s.we = we; s.wa = wa;
      s.wmask = wm; s.di = di; s.byp = byp; s.dbyp = dbyp;
      return s;
   endfunction

   function automatic vec_t mk(bit re, int ra, bit ore, bit we, int wa, int wm,
                               logic [15:0] di, bit byp, logic [15:0] dbyp,
                               logic [15:0] ed, bit ev, bit ee);
      vec_t v;
      v.s = st(re, ra, ore, we, wa, wm, 64'(di), byp, 64'(dbyp));
      v.exp_dout = ed; v.exp_vld = ev; v.exp_err = ee;
      return v;
   endfunction

   task automatic apply(input int inst, input stim_t s);
      case (inst)
         0: begin
            re_a = s.re; ra_a = s.ra[4:0]; ore_a = s.ore; we_a = s.we; wa_a = s.wa[4:0];
            wm_a = s.wmask[1:0]; di_a = s.di[15:0]; byp_a = s.byp; dbyp_a = s.dbyp[15:0];
         end
         1: begin
            re_b = s.re; ra_b = s.ra[5:0]; ore_b = s.ore; we_b = s.we; wa_b = s.wa[5:0];
            wm_b = s.wmask[3:0]; di_b = s.di[31:0]; byp_b = s.byp; dbyp_b = s.dbyp[31:0];
         end
         default: begin
            re_c = s.re; ra_c = s.ra[1:0]; ore_c = s.ore; we_c = s.we; wa_c = s.wa[1:0];
            wm_c = s.wmask[0:0]; di_c = s.di[8:0]; byp_c = s.byp; dbyp_c = s.dbyp[8:0];
         end
      endcase
   endtask

   task automatic sample(input int inst, output logic [63:0] d, output bit v, output bit e);
      case (inst)
         0:       begin d = 64'(dout_a); v = vld_a; e = err_a; end
         1:       begin d = 64'(dout_b); v = vld_b; e = err_b; end
         default: begin d = 64'(dout_c); v = vld_c; e = err_c; end
      endcase
   endtask

   // Drive at a negedge, let one rising edge pass, sample at the next negedge.
   task automatic step(input int inst, input stim_t s,
                       output logic [63:0] d, output bit v, output bit e);
      apply(inst, s);
      @(posedge clk);
      @(negedge clk);
      sample(inst, d, v, e);
   endtask

   task automatic run_random(input int inst, input int n);
      int          dep, wid, mg, aw, mw;
      logic [63:0] m [1024];
      logic [63:0] dm, lm, exp_dout, d;
      bit          pend, oor, exp_vld, exp_err, v, e;
      int          addr;
      stim_t       s;
      case (inst)
         0:       begin dep = 20; wid = 16; mg = 8; aw = 5; end
         1:       begin dep = 64; wid = 32; mg = 8; aw = 6; end
         default: begin dep = 3;  wid = 9;  mg = 9; aw = 2; end
      endcase
      mw = wid / mg;
      dm = (64'd1 << wid) - 64'd1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) apply(k, idle());
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      pend = 0; oor = 0; addr = 0; exp_dout = 0; exp_vld = 0; exp_err = 0;
      for (int i = 0; i < dep + n; i++) begin
         if (i < dep) begin
            s = st(0, 0, 0, 1, i, (1 << mw) - 1, {$urandom(), $urandom()} & dm, 0, 0);
         end else begin
            s = st($urandom_range(0, 1) == 1, $urandom_range(0, (1 << aw) - 1),
                   $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                   $urandom_range(0, (1 << aw) - 1), $urandom_range(0, (1 << mw) - 1),
                   {$urandom(), $urandom()} & dm, $urandom_range(0, 4) == 0,
                   {$urandom(), $urandom()} & dm);
         end
         step(inst, s, d, v, e);
         // Output register sees the array as it was before this edge's write.
         if (s.ore) begin
            exp_dout = s.byp ? s.dbyp : (oor ? 64'd0 : m[addr]);
            exp_vld  = s.byp | pend;
         end
         if (s.re) begin
            pend = 1; addr = int'(s.ra); oor = (s.ra >= dep);
         end else if (s.ore) begin
            pend = 0;
         end
         if ((s.re && s.ra >= dep) || (s.we && s.wa >= dep)) exp_err = 1;
         if (s.we && s.wa < dep) begin
            for (int l = 0; l < mw; l++) begin
               if (s.wmask[l]) begin
                  lm = ((64'd1 << mg) - 64'd1) << (l * mg);
                  m[s.wa] = (m[s.wa] & ~lm) | (s.di & lm);
               end
            end
         end
         check($sformatf("rnd%0d.%0d dout", inst, i), d, exp_dout);
         check($sformatf("rnd%0d.%0d vld", inst, i), 64'(v), 64'(exp_vld));
         check($sformatf("rnd%0d.%0d err", inst, i), 64'(e), 64'(exp_err));
      end
   endtask

   initial begin
      vec_t        vt[$];
      logic [63:0] d;
      bit          v, e;

      // Directed table on the 20 x 16 instance; each row is one clock.
      //           re ra ore we wa wm  di       byp dbyp     exp_dout vld err
      vt.push_back(mk(0, 0, 0, 1, 3, 3, 16'hA5A5, 0, 16'h0000, 16'h0000, 0, 0));
      vt.push_back(mk(1, 3, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 1, 0));
      vt.push_back(mk(0, 0, 0, 1, 7, 3, 16'h1234, 0, 16'h0000, 16'hA5A5, 1, 0));
      vt.push_back(mk(0, 0, 0, 1, 7, 1, 16'hFFFF, 0, 16'h0000, 16'hA5A5, 1, 0));
      vt.push_back(mk(1, 7, 0, 1, 7, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 1, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h12FF, 1, 0));
      vt.push_back(mk(0, 0, 0, 1, 5, 3, 16'h0001, 0, 16'h0000, 16'h12FF, 1, 0));
      vt.push_back(mk(1, 5, 0, 1, 5, 3, 16'hBEEF, 0, 16'h0000, 16'h12FF, 1, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hBEEF, 1, 0));
      vt.push_back(mk(1, 5, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hBEEF, 1, 0));
      vt.push_back(mk(0, 0, 1, 1, 5, 3, 16'h7777, 0, 16'h0000, 16'hBEEF, 1, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h7777, 0, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 1, 16'h5A5A, 16'h5A5A, 1, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h7777, 0, 0));
      vt.push_back(mk(1, 3, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h7777, 0, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 1, 0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 0, 0));
      vt.push_back(mk(0, 0, 0, 1, 25, 3, 16'hFFFF, 0, 16'h0000, 16'hA5A5, 0, 1));
      vt.push_back(mk(1, 31, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 0, 1));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1));
      vt.push_back(mk(1, 3, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 1, 1));
      vt.push_back(mk(0, 0, 0, 1, 19, 3, 16'h1919, 0, 16'h0000, 16'hA5A5, 1, 1));

      pwr  = 32'h0;
      rstn = 1'b0;
      for (int k = 0; k < 3; k++) apply(k, idle());
      repeat (2) @(negedge clk);
      sample(0, d, v, e);
      check("reset dout", d, 64'h0);
      check("reset vld", 64'(v), 64'h0);
      check("reset err", 64'(e), 64'h0);
      rstn = 1'b1;

      foreach (vt[i]) begin
         step(0, vt[i].s, d, v, e);
         check($sformatf("vec%0d dout", i), d, 64'(vt[i].exp_dout));
         check($sformatf("vec%0d vld", i), 64'(v), 64'(vt[i].exp_vld));
         check($sformatf("vec%0d err", i), 64'(e), 64'(vt[i].exp_err));
      end

      // Asynchronous reset between the re edge and the ore edge.
      step(0, st(1, 7, 0, 0, 0, 0, 0, 0, 0), d, v, e);
      apply(0, idle());
      #2 rstn = 1'b0;
      #1 sample(0, d, v, e);
      check("async rst dout", d, 64'h0);
      check("async rst vld", 64'(v), 64'h0);
      check("async rst err", 64'(e), 64'h0);
      @(negedge clk);
      rstn = 1'b1;
      step(0, st(0, 0, 1, 0, 0, 0, 0, 0, 0), d, v, e);
      check("post rst ore vld", 64'(v), 64'h0);
      step(0, st(1, 7, 0, 0, 0, 0, 0, 0, 0), d, v, e);
      step(0, st(0, 0, 1, 0, 0, 0, 0, 0, 0), d, v, e);
      check("retained dout", d, 64'h12FF);
      check("retained vld", 64'(v), 64'h1);

      // Last legal address versus first illegal one.
      step(0, st(1, 19, 0, 0, 0, 0, 0, 0, 0), d, v, e);
      check("ra=19 err", 64'(e), 64'h0);
      step(0, st(0, 0, 1, 0, 0, 0, 0, 0, 0), d, v, e);
      check("ra=19 dout", d, 64'h1919);
      check("ra=19 err2", 64'(e), 64'h0);
      step(0, st(0, 0, 0, 1, 20, 3, 64'h2020, 0, 0), d, v, e);
      check("wa=20 err", 64'(e), 64'h1);
      step(0, st(1, 20, 0, 0, 0, 0, 0, 0, 0), d, v, e);
      step(0, st(0, 0, 1, 0, 0, 0, 0, 0, 0), d, v, e);
      check("ra=20 dout", d, 64'h0);
      check("ra=20 vld", 64'(v), 64'h1);

      run_random(0, 400);
      run_random(1, 400);
      run_random(2, 400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
